// File: rtl/regfile_read_sched.sv
// regfile_read_sched
//   Operand-fetch sequencer for the decode stage. Time-multiplexes the rs1/rs2
//   reads over a single synchronous (1-cycle latency) register-file read port,
//   forces x0 operands to zero, and steers write-back onto the write port,
//   parking it on x0 when idle.
//
// Optional feature macro: REGSCHED_BYPASS_EN
//   When defined, write-back data addressed to a captured nonzero source index
//   replaces that operand, from the cycle the register is selected through the
//   response handshake cycle. Latency is the same with or without it.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        operand-fetch request handshake
//   req_rs1, req_rs2           source indices
//   req_use_rs2                1 = fetch both operands, 0 = rs1 only
//   rsp_valid/rsp_ready        operand response handshake
//   rsp_rs1_data, rsp_rs2_data returned operands (rs2 is 0 when unused)
//   wb_valid, wb_rd, wb_data   write-back request, always accepted
//   rf_read_select             register-file read select
//   rf_read_data               register-file read data (select of previous cycle)
//   rf_write_select            register-file write select
//   rf_write_data              register-file write data
//
// state | meaning
// IDLE  | ready for a request; read port driven from req_rs1
// READ1 | rs1 data on the read port; rs2 selected if needed
// READ2 | rs2 data on the read port
// RESP  | operands valid, held until rsp_ready
module regfile_read_sched #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    input  logic            req_use_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rs1_data,
    output logic [XLEN-1:0] rsp_rs2_data,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW-1:0]   rf_read_select,
    input  logic [XLEN-1:0] rf_read_data,
    output logic [AW-1:0]   rf_write_select,
    output logic [XLEN-1:0] rf_write_data
);

    typedef enum logic [1:0] {IDLE, READ1, READ2, RESP} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   rs1_q, rs2_q, sel_q;
    logic            use_rs2_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] cap1, cap2;
    logic            accept;

    assign accept = req_valid && req_ready;

`ifdef REGSCHED_BYPASS_EN
    // A write in the accept cycle commits after the read port sampled rs1,
    // and a write in READ1 commits after it sampled rs2; those are parked
    // here until the capture cycle.
    logic            pend1, pend2;
    logic [XLEN-1:0] pdata1, pdata2;
    logic            wb_hit1, wb_hit2, wb_hit_req1;

    assign wb_hit1     = wb_valid && (wb_rd == rs1_q) && (rs1_q != '0);
    assign wb_hit2     = wb_valid && (wb_rd == rs2_q) && (rs2_q != '0) && use_rs2_q;
    assign wb_hit_req1 = wb_valid && (wb_rd == req_rs1) && (req_rs1 != '0);

    assign cap1 = (rs1_q == '0) ? '0 :
                  wb_hit1       ? wb_data :
                  pend1         ? pdata1 : rf_read_data;
    assign cap2 = (rs2_q == '0) ? '0 :
                  wb_hit2       ? wb_data :
                  pend2         ? pdata2 : rf_read_data;

    // A write in the handshake cycle itself reaches the consumer directly.
    assign rsp_rs1_data = (state == RESP && wb_hit1) ? wb_data : op1_q;
    assign rsp_rs2_data = (state == RESP && wb_hit2) ? wb_data : op2_q;
`else
    assign cap1 = (rs1_q == '0) ? '0 : rf_read_data;
    assign cap2 = (rs2_q == '0) ? '0 : rf_read_data;

    assign rsp_rs1_data = op1_q;
    assign rsp_rs2_data = op2_q;
`endif

    assign rsp_valid = (state == RESP) && !reset;

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        rf_read_select = sel_q;
        case (state)
            IDLE: begin
                req_ready      = !reset;
                rf_read_select = req_rs1;
                if (req_valid && !reset) state_next = READ1;
            end
            READ1: begin
                if (use_rs2_q) begin
                    rf_read_select = rs2_q;
                    state_next     = READ2;
                end else begin
                    state_next = RESP;
                end
            end
            READ2: state_next = RESP;
            RESP:  if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rf_write_select = '0;
        rf_write_data   = '0;
        if (wb_valid && !reset) begin
            rf_write_select = wb_rd;
            rf_write_data   = (wb_rd == '0) ? '0 : wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs2_q <= 1'b0;
            sel_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
`ifdef REGSCHED_BYPASS_EN
            pend1     <= 1'b0;
            pend2     <= 1'b0;
            pdata1    <= '0;
            pdata2    <= '0;
`endif
        end else begin
            state <= state_next;
            sel_q <= rf_read_select;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        use_rs2_q <= req_use_rs2;
`ifdef REGSCHED_BYPASS_EN
                        pend1     <= wb_hit_req1;
                        pdata1    <= wb_data;
                        pend2     <= 1'b0;
`endif
                    end
                end
                READ1: begin
                    op1_q <= cap1;
                    if (!use_rs2_q) op2_q <= '0;
`ifdef REGSCHED_BYPASS_EN
                    pend2  <= wb_hit2;
                    pdata2 <= wb_data;
`endif
                end
                READ2: begin
                    op2_q <= cap2;
`ifdef REGSCHED_BYPASS_EN
                    if (wb_hit1) op1_q <= wb_data;
`endif
                end
                RESP: begin
`ifdef REGSCHED_BYPASS_EN
                    if (wb_hit1) op1_q <= wb_data;
                    if (wb_hit2) op2_q <= wb_data;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_sched.sv
module tb_regfile_read_sched;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [AW-1:0]   req_rs1 = '0;
    logic [AW-1:0]   req_rs2 = '0;
    logic            req_use_rs2 = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_rs1_data, rsp_rs2_data;
    logic            wb_valid = 1'b0;
    logic [AW-1:0]   wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic [AW-1:0]   rf_read_select;
    logic [XLEN-1:0] rf_read_data;
    logic [AW-1:0]   rf_write_select;
    logic [XLEN-1:0] rf_write_data;

    int errors = 0;
    int checks = 0;

    regfile_read_sched #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_rs2(req_use_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_read_select(rf_read_select), .rf_read_data(rf_read_data),
        .rf_write_select(rf_write_select), .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    // Register-file model: synchronous read with pre-write value on a
    // same-cycle write. x0 is not hardwired here, so reading it returns junk.
    logic [XLEN-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (reset) rf_read_data <= '0;
        else       rf_read_data <= (rf_read_select == '0) ? 32'hBAD0_BAD0 : mem[rf_read_select];
        mem[rf_write_select] <= rf_write_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        tick();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h/%h exp=0/0", rsp_rs1_data, rsp_rs2_data); end
        checks++; if (rf_write_select !== 5'd0 || rf_write_data !== 32'h0) begin errors++; $display("FAIL reset_write_port got=%0d/%h exp=0/0", rf_write_select, rf_write_data); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
        tick();
    endtask

    task automatic test_two_operand();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        @(negedge clk);
        checks++; if (rf_write_select !== 5'd5 || rf_write_data !== 32'h1234) begin errors++; $display("FAIL wb_steer got=%0d/%h exp=5/00001234", rf_write_select, rf_write_data); end
        tick();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_use_rs2 = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rf_read_select !== 5'd5) begin errors++; $display("FAIL accept_T got ready=%b sel=%0d exp 1/5", req_ready, rf_read_select); end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rf_read_select !== 5'd0) begin errors++; $display("FAIL read1_T1 got valid=%b sel=%0d exp 0/0", rsp_valid, rf_read_select); end
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read2_T2 rsp_valid got=%b exp=0", rsp_valid); end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL resp_T3 rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_rs1_data !== 32'h1234 || rsp_rs2_data !== 32'h0) begin errors++; $display("FAIL two_op_data got=%h/%h exp=00001234/00000000", rsp_rs1_data, rsp_rs2_data); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        wb_write(5'd3, 32'hA5A5_A5A5);
        req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd9; req_use_rs2 = 1'b0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rs1only_T1 rsp_valid got=%b exp=0", rsp_valid); end
        tick();
        req_valid = 1'b1; req_rs1 = 5'd5; req_use_rs2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL stall_%0d valid=%b ready=%b exp 1/0", k, rsp_valid, req_ready); end
            checks++; if (rsp_rs1_data !== 32'hA5A5_A5A5 || rsp_rs2_data !== 32'h0) begin errors++; $display("FAIL stall_data_%0d got=%h/%h exp=a5a5a5a5/00000000", k, rsp_rs1_data, rsp_rs2_data); end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL after_handshake ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp1;
`ifdef REGSCHED_BYPASS_EN
        exp1 = 32'hDEAD;
`else
        exp1 = 32'h1111;
`endif
        wb_write(5'd7, 32'h1111);
        req_valid = 1'b1; req_rs1 = 5'd7; req_use_rs2 = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        tick();
        req_valid = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== exp1) begin errors++; $display("FAIL same_cycle_wb valid=%b rs1=%h exp 1/%h", rsp_valid, rsp_rs1_data, exp1); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_x0();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (rf_write_select !== 5'd0 || rf_write_data !== 32'h0) begin errors++; $display("FAIL x0_write got=%0d/%h exp=0/0", rf_write_select, rf_write_data); end
        tick();
        wb_valid = 1'b0; wb_rd = 5'd9; wb_data = 32'h5555_5555;
        @(negedge clk);
        checks++; if (rf_write_select !== 5'd0 || rf_write_data !== 32'h0) begin errors++; $display("FAIL parked_write got=%0d/%h exp=0/0", rf_write_select, rf_write_data); end
        req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd5; req_use_rs2 = 1'b1;
        tick();
        req_valid = 1'b0; wb_rd = '0; wb_data = '0;
        tick(); tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h1234) begin errors++; $display("FAIL x0_read valid=%b got=%h/%h exp 1/00000000/00001234", rsp_valid, rsp_rs1_data, rsp_rs2_data); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd3; req_use_rs2 = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL reset_in_read2 valid=%b ready=%b exp 0/0", rsp_valid, req_ready); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dropped_req_%0d rsp_valid got=%b exp=0", k, rsp_valid); end
        end
        tick();
        req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd5; req_use_rs2 = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hA5A5_A5A5 || rsp_rs2_data !== 32'h1234) begin errors++; $display("FAIL post_reset_req valid=%b got=%h/%h exp 1/a5a5a5a5/00001234", rsp_valid, rsp_rs1_data, rsp_rs2_data); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]   r1 [2];
        logic [AW-1:0]   r2 [2];
        logic [XLEN-1:0] e1 [2];
        logic [XLEN-1:0] e2 [2];
        r1[0] = 5'd5; r2[0] = 5'd3; e1[0] = 32'h1234;      e2[0] = 32'hA5A5_A5A5;
        r1[1] = 5'd7; r2[1] = 5'd5; e1[1] = 32'hDEAD;      e2[1] = 32'h1234;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_rs1 = r1[i]; req_rs2 = r2[i]; req_use_rs2 = 1'b1;
            @(negedge clk);
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d req_ready got=%b exp=1", i, req_ready); end
            tick();
            for (int k = 1; k < 3; k++) begin
                @(negedge clk);
                checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_%0d_%0d valid=%b ready=%b exp 0/0", i, k, rsp_valid, req_ready); end
                tick();
            end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== e1[i] || rsp_rs2_data !== e2[i]) begin errors++; $display("FAIL b2b_resp_%0d valid=%b got=%h/%h exp 1/%h/%h", i, rsp_valid, rsp_rs1_data, rsp_rs2_data, e1[i], e2[i]); end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_two_operand();
        test_stall();
        test_bypass();
        test_x0();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
